// File: rtl/ycbcr_centroid.sv
// Cb/Cr window mask with per-frame coordinate accumulation and a sequential
// restoring divider that reports the mask centroid after each vsync rising edge.
//
//   state | meaning
//   IDLE  | waiting for a frame end; results hold
//   DIV_X | restoring division sum_x / cnt, one quotient bit per cycle
//   DIV_Y | restoring division sum_y / cnt, one quotient bit per cycle
//   DONE  | new centroid visible, centroid_valid high for one cycle
module ycbcr_centroid #(
   parameter int         H_BITS     = 11,
   parameter int         V_BITS     = 11,
   parameter logic [7:0] CB_MIN     = 8'd77,
   parameter logic [7:0] CB_MAX     = 8'd127,
   parameter logic [7:0] CR_MIN     = 8'd133,
   parameter logic [7:0] CR_MAX     = 8'd173,
   parameter int         MIN_PIXELS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [23:0]       pixel_in,
   output logic              de_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic [23:0]       pixel_out,
   output logic [H_BITS-1:0] centroid_x,
   output logic [V_BITS-1:0] centroid_y,
   output logic              obj_present,
   output logic              centroid_valid,
   output logic              busy
);

   localparam int MAXB = (H_BITS > V_BITS) ? H_BITS : V_BITS;
   localparam int SW   = H_BITS + V_BITS + MAXB;
   localparam int CW   = H_BITS + V_BITS;
   localparam int BCW  = $clog2(SW);
   localparam logic [BCW-1:0] LAST = BCW'(SW - 1);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   state_t state, state_nxt;

   logic [7:0]        cb, cr;
   logic              mask;
   logic              frame_end, de_fall;
   logic [H_BITS-1:0] x;
   logic [V_BITS-1:0] y;
   logic [SW-1:0]     acc_x, acc_y, sum_x_nxt, sum_y_nxt;
   logic [CW-1:0]     acc_cnt, cnt_nxt;
   logic              enough, start, empty, empty_q, last;

   logic [SW-1:0]     dvd, dvd_nxt, snap_y;
   logic [CW-1:0]     rem, rem_nxt, divisor;
   logic [CW:0]       trial;
   logic              ge;
   logic [BCW-1:0]    bit_cnt;
   logic [H_BITS-1:0] qx;

   // luma takes no part in the mask decision
   logic unused_luma;
   assign unused_luma = ^pixel_in[23:16];

   assign cb   = pixel_in[15:8];
   assign cr   = pixel_in[7:0];
   assign mask = de_in && (cb >= CB_MIN) && (cb <= CB_MAX)
                       && (cr >= CR_MIN) && (cr <= CR_MAX);

   // the delayed video outputs double as the edge-detect history
   assign frame_end = vsync_in & ~vsync_out;
   assign de_fall   = de_out & ~de_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         pixel_out <= '0;
      end else begin
         de_out    <= de_in;
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
         pixel_out <= mask ? 24'hFFFFFF : 24'h000000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else begin
         x <= de_in ? x + H_BITS'(1) : '0;
         if (frame_end)
            y <= '0;
         else if (de_fall)
            y <= y + V_BITS'(1);
      end
   end

   // snapshot values include a mask pixel sampled on the frame-end cycle
   assign sum_x_nxt = acc_x + (mask ? SW'(x) : '0);
   assign sum_y_nxt = acc_y + (mask ? SW'(y) : '0);
   assign cnt_nxt   = acc_cnt + CW'(mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_x   <= '0;
         acc_y   <= '0;
         acc_cnt <= '0;
      end else if (frame_end) begin
         acc_x   <= '0;
         acc_y   <= '0;
         acc_cnt <= '0;
      end else begin
         acc_x   <= sum_x_nxt;
         acc_y   <= sum_y_nxt;
         acc_cnt <= cnt_nxt;
      end
   end

   assign enough = (cnt_nxt >= CW'(MIN_PIXELS));
   assign start  = frame_end && (state == IDLE) && enough;
   assign empty  = frame_end && (state == IDLE) && !enough;
   assign last   = (bit_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DIV_X;
         DIV_X:   if (last)  state_nxt = DIV_Y;
         DIV_Y:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy           = (state != IDLE);
      centroid_valid = (state == DONE) || empty_q;
   end

   assign trial   = {rem, dvd[SW-1]};
   assign ge      = (trial >= {1'b0, divisor});
   assign rem_nxt = ge ? CW'(trial - {1'b0, divisor}) : trial[CW-1:0];
   assign dvd_nxt = {dvd[SW-2:0], ge};

   // dividend register shifts the quotient in from the bottom
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd     <= '0;
         rem     <= '0;
         divisor <= '0;
         snap_y  <= '0;
         bit_cnt <= '0;
         qx      <= '0;
      end else if (start) begin
         dvd     <= sum_x_nxt;
         snap_y  <= sum_y_nxt;
         divisor <= cnt_nxt;
         rem     <= '0;
         bit_cnt <= '0;
      end else if (state == DIV_X || state == DIV_Y) begin
         dvd     <= dvd_nxt;
         rem     <= rem_nxt;
         bit_cnt <= bit_cnt + BCW'(1);
         if (last) begin
            bit_cnt <= '0;
            if (state == DIV_X) begin
               qx  <= dvd_nxt[H_BITS-1:0];
               dvd <= snap_y;
               rem <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         centroid_x  <= '0;
         centroid_y  <= '0;
         obj_present <= 1'b0;
         empty_q     <= 1'b0;
      end else begin
         empty_q <= empty;
         if (empty)
            obj_present <= 1'b0;
         else if (state == DIV_Y && last) begin
            centroid_x  <= qx;
            centroid_y  <= dvd_nxt[V_BITS-1:0];
            obj_present <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ycbcr_centroid.sv
// Directed bench for ycbcr_centroid: expected centroid results are queued when
// the frame-end vsync edge is driven and checked by a monitor on each valid pulse.
module tb_ycbcr_centroid;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        de_in = 1'b0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic [23:0] pixel_in = '0;
   logic        de_out, hsync_out, vsync_out;
   logic [23:0] pixel_out;
   logic [10:0] centroid_x;
   logic [10:0] centroid_y;
   logic        obj_present, centroid_valid, busy;

   ycbcr_centroid dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .de_in          (de_in),
      .hsync_in       (hsync_in),
      .vsync_in       (vsync_in),
      .pixel_in       (pixel_in),
      .de_out         (de_out),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .pixel_out      (pixel_out),
      .centroid_x     (centroid_x),
      .centroid_y     (centroid_y),
      .obj_present    (obj_present),
      .centroid_valid (centroid_valid),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      int x;
      int y;
      int obj;
      int at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (centroid_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got pulse at cycle %0d want none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(mon_e.at));
            chk("pulse_cx", 32'(centroid_x), 32'(mon_e.x));
            chk("pulse_cy", 32'(centroid_y), 32'(mon_e.y));
            chk("pulse_obj", 32'(obj_present), 32'(mon_e.obj));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] pix(input int mode, input int c, input int r);
      if ((mode == 1 && c == 5 && r == 2) ||
          (mode == 2 && c >= 2 && c <= 3 && r >= 1 && r <= 2))
         return 24'h506496;
      return 24'h500000;
   endfunction

   task automatic send_frame(input int mode);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            de_in    = 1'b1;
            pixel_in = pix(mode, c, r);
            step();
         end
         de_in    = 1'b0;
         pixel_in = '0;
         step();
         hsync_in = 1'b1;
         step();
         hsync_in = 1'b0;
         step();
      end
   endtask

   task automatic vsync_frame(input int ex, input int ey, input int eo, input int lat,
                              output int t);
      vsync_in = 1'b1;
      t = cyc;
      sb.push_back('{ex, ey, eo, t + lat});
      step();
      step();
      vsync_in = 1'b0;
      step();
      step();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_de"},    32'(de_out),         32'd0);
      chk({tag, "_hs"},    32'(hsync_out),      32'd0);
      chk({tag, "_vs"},    32'(vsync_out),      32'd0);
      chk({tag, "_pix"},   32'(pixel_out),      32'd0);
      chk({tag, "_cx"},    32'(centroid_x),     32'd0);
      chk({tag, "_cy"},    32'(centroid_y),     32'd0);
      chk({tag, "_obj"},   32'(obj_present),    32'd0);
      chk({tag, "_valid"}, 32'(centroid_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy),           32'd0);
   endtask

   initial begin
      int t;

      // reset held during active video
      de_in    = 1'b1;
      pixel_in = 24'h506496;
      hsync_in = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check_zero("rst");
      step();
      de_in    = 1'b0;
      hsync_in = 1'b0;
      pixel_in = '0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check_zero("post_rst");
      step();

      // first frame end has nothing in the mask
      vsync_frame(0, 0, 0, 1, t);
      repeat (5) step();

      send_frame(1);
      vsync_frame(5, 2, 1, 67, t);
      repeat (75) step();

      send_frame(2);
      vsync_frame(2, 1, 1, 67, t);
      repeat (75) step();

      send_frame(0);
      vsync_frame(2, 1, 0, 1, t);
      repeat (5) step();

      // mask passthrough; the in-window pixel lands at (0,0) of the next frame
      de_in    = 1'b1;
      pixel_in = 24'h506496;
      step();
      pixel_in = 24'h501010;
      @(negedge clk);
      chk("pt_pix_in", 32'(pixel_out), 32'hFFFFFF);
      chk("pt_de_in", 32'(de_out), 32'd1);
      chk("pt_hs_lo", 32'(hsync_out), 32'd0);
      step();
      de_in    = 1'b0;
      hsync_in = 1'b1;
      pixel_in = '0;
      @(negedge clk);
      chk("pt_pix_out", 32'(pixel_out), 32'h000000);
      chk("pt_de_b", 32'(de_out), 32'd1);
      step();
      hsync_in = 1'b0;
      @(negedge clk);
      chk("pt_de_lo", 32'(de_out), 32'd0);
      chk("pt_hs_hi", 32'(hsync_out), 32'd1);
      step();
      step();

      // second vsync edge 10 cycles into DIV_X is dropped
      vsync_in = 1'b1;
      t = cyc;
      sb.push_back('{0, 0, 1, t + 67});
      chk("pre_drop_vs", 32'(vsync_out), 32'd0);
      repeat (3) step();
      vsync_in = 1'b0;
      repeat (8) step();
      @(negedge clk);
      chk("drop_busy", 32'(busy), 32'd1);
      vsync_in = 1'b1;
      step();
      step();
      vsync_in = 1'b0;
      repeat (75) step();

      send_frame(2);
      vsync_frame(2, 1, 1, 67, t);
      repeat (75) step();

      // reset pulsed during DIV_Y: no pulse, everything back to zero
      send_frame(1);
      vsync_in = 1'b1;
      t = cyc;
      step();
      step();
      vsync_in = 1'b0;
      repeat (38) step();
      @(negedge clk);
      chk("divy_busy", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      step();
      step();
      rst_n = 1'b1;
      repeat (80) step();
      @(negedge clk);
      chk("after_rst_obj", 32'(obj_present), 32'd0);
      chk("after_rst_cx", 32'(centroid_x), 32'd0);
      chk("after_rst_busy", 32'(busy), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ycbcr_centroid.md
# ycbcr_centroid

Thresholds each YCbCr pixel from the colour-space converter against a Cb/Cr window and builds a binary object mask. Over each frame it accumulates the x/y coordinate sums and pixel count of the mask. At frame end it computes the object centroid with a sequential restoring divider. It sits directly downstream of the RGB→YCbCr stage and forwards the mask as a video stream with aligned sync signals.

## Interface
- H_BITS, 11, width of column counter and centroid_x
- V_BITS, 11, width of row counter and centroid_y
- CB_MIN, 8'd77, inclusive lower Cb bound
- CB_MAX, 8'd127, inclusive upper Cb bound
- CR_MIN, 8'd133, inclusive lower Cr bound
- CR_MAX, 8'd173, inclusive upper Cr bound
- MIN_PIXELS, 1, minimum mask count for an object to be reported
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- de_in  in  1  data enable
- hsync_in  in  1  horizontal sync, active high
- vsync_in  in  1  vertical sync, active high
- pixel_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}
- de_out / hsync_out / vsync_out  out  1  inputs delayed by 1 cycle
- pixel_out  out  24  24'hFFFFFF when the pixel is in the mask, else 24'h000000; delayed by 1 cycle
- centroid_x  out  H_BITS  last computed centroid column
- centroid_y  out  V_BITS  last computed centroid row
- obj_present  out  1  last frame's mask count was ≥ MIN_PIXELS
- centroid_valid  out  1  one-cycle pulse when the results update
- busy  out  1  divider running

## Operation
- mask = de_in & (CB_MIN ≤ Cb ≤ CB_MAX) & (CR_MIN ≤ Cr ≤ CR_MAX). All comparisons are unsigned.
- Column counter x:
  - Increments on every de_in=1 cycle.
  - Clears to 0 on the cycle after de_in falls.
  - The first pixel of a line is x=0.
- Row counter y:
  - Increments on each falling edge of de_in.
  - Clears to 0 on a rising edge of vsync_in.
  - The first line is y=0.
- Counter wrap: x and y wrap modulo 2^H_BITS and 2^V_BITS. There is no saturation.
- Accumulators. On each mask=1 cycle:
  - sum_x += x
  - sum_y += y
  - cnt += 1
- Accumulator widths: SW = H_BITS+V_BITS+max(H_BITS,V_BITS) for sum_x and sum_y; H_BITS+V_BITS for cnt.
- Frame end is a rising edge of vsync_in, sampled at cycle t:
  - The final sums are snapshotted, including any mask pixel sampled at t.
  - The accumulators clear at t+1.
- Divider FSM states: IDLE → DIV_X → DIV_Y → DONE → IDLE.
  - IDLE → DIV_X at the frame-end edge when cnt_snapshot ≥ MIN_PIXELS.
  - DIV_X: restoring division sum_x/cnt, one quotient bit per cycle, SW cycles.
  - DIV_Y: same for sum_y/cnt, SW cycles.
  - DONE: loads the truncated quotients, with low bits taken into centroid_x/centroid_y. Sets obj_present=1 and pulses centroid_valid. Returns to IDLE.
- cnt_snapshot < MIN_PIXELS, including 0:
  - No division is done.
  - obj_present=0 and centroid_valid pulses at t+1.
  - centroid_x and centroid_y hold their previous values.
- busy=1 in DIV_X, DIV_Y and DONE.
- A frame-end edge while busy=1 is dropped: no snapshot and no result for that frame. The accumulators still clear.

## Timing
- Video path latency is 1 cycle for de, hsync, vsync and pixel. All four stay aligned.
- Centroid latency:
  - centroid_valid is high at cycle t+2·SW+1.
  - With default parameters SW=33, so the pulse is at t+67.
  - The new values are visible in the same cycle as the pulse.
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0 immediately.
  - Counters and accumulators clear; the FSM goes to IDLE.
  - A division in progress is abandoned and no valid pulse is produced.
- The first frame after reset starts at the first vsync rising edge. Pixels seen before that edge are accumulated, then discarded by the snapshot rules only if that frame is dropped.

## Test plan
- Reset: hold rst_n=0 during active video → all outputs 0, busy=0. Release rst_n → outputs remain 0 until the first frame end.
- Single pixel: 8×4 frame, one pixel at (x=5, y=2) with Cb=100, Cr=150, all other pixels Cb=Cr=0 → centroid (5,2), obj_present=1, centroid_valid exactly 67 cycles after the vsync edge.
- Block with truncation: pixels (2..3, 1..2) in mask → sum_x=10, sum_y=6, cnt=4 → centroid (2,1).
- Empty frame after the block test → valid at t+1, obj_present=0, centroid stays (2,1).
- Mask passthrough: pixel_in=24'h50_64_96 with de_in=1 → pixel_out=24'hFFFFFF and de_out=1 on the next cycle. Pixel 24'h50_10_10 → 24'h000000.
- Mid-operation events:
  - A second vsync edge 10 cycles into DIV_X → only one valid pulse, carrying the first frame's result.
  - rst_n pulsed low during DIV_Y → outputs 0 and no pulse.
